// File: rtl/nasti_lite_stim_seq.sv
// Script-driven NASTI-lite register bus master: WRITE / READ / POLL / END commands from a loadable table.
// One command in flight at a time; each channel's valid holds until its own handshake; b_ready and r_ready are always 1.
module nasti_lite_stim_seq #(
  parameter int ADDR_WIDTH   = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 32,
  parameter int POLL_TIMEOUT = 1024,
  parameter int CMD_WIDTH    = 2 + ADDR_WIDTH + 2 * DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [CMD_WIDTH-1:0]     prog_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [$clog2(DEPTH)-1:0] pc,
  output logic [DATA_WIDTH-1:0]    last_rdata,
  output logic [ADDR_WIDTH-1:0]    aw_addr,
  output logic                     aw_valid,
  input  logic                     aw_ready,
  output logic [DATA_WIDTH-1:0]    w_data,
  output logic                     w_valid,
  input  logic                     w_ready,
  input  logic [1:0]               b_resp,
  input  logic                     b_valid,
  output logic                     b_ready,
  output logic [ADDR_WIDTH-1:0]    ar_addr,
  output logic                     ar_valid,
  input  logic                     ar_ready,
  input  logic [DATA_WIDTH-1:0]    r_data,
  input  logic [1:0]               r_resp,
  input  logic                     r_valid,
  output logic                     r_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(POLL_TIMEOUT + 1);
  localparam logic [PW-1:0] PC_LAST    = PW'(DEPTH - 1);
  localparam logic [CW-1:0] POLL_LIMIT = CW'(POLL_TIMEOUT);

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_POLL  = 2'd2;
  localparam logic [1:0] OP_END   = 2'd3;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_FETCH = 4'd1;
  localparam logic [3:0] S_WR    = 4'd2;
  localparam logic [3:0] S_WB    = 4'd3;
  localparam logic [3:0] S_RA    = 4'd4;
  localparam logic [3:0] S_RD    = 4'd5;
  localparam logic [3:0] S_ADV   = 4'd6;
  localparam logic [3:0] S_DONE  = 4'd7;
  localparam logic [3:0] S_ERR   = 4'd8;

  logic [CMD_WIDTH-1:0]  mem [DEPTH];
  logic [CMD_WIDTH-1:0]  fw;
  logic [1:0]            f_op;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic [DATA_WIDTH-1:0] f_data;
  logic [DATA_WIDTH-1:0] f_mask;

  logic [3:0]            state;
  logic [1:0]            cur_op;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [DATA_WIDTH-1:0] cur_mask;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic                  aw_fin;
  logic                  w_fin;
  logic                  poll_match;

  assign b_ready = 1'b1;
  assign r_ready = 1'b1;

  // Script memory has no reset so a loaded script survives a mid-run reset.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) begin
      mem[prog_addr] <= prog_data;
    end
  end

  assign fw     = mem[pc];
  assign f_op   = fw[CMD_WIDTH-1 -: 2];
  assign f_addr = fw[2*DATA_WIDTH +: ADDR_WIDTH];
  assign f_data = fw[DATA_WIDTH +: DATA_WIDTH];
  assign f_mask = fw[DATA_WIDTH-1:0];

  assign aw_fin     = !aw_valid || aw_ready;
  assign w_fin      = !w_valid || w_ready;
  assign cnt_nxt    = cnt + 1'b1;
  assign poll_match = ((r_data ^ cur_data) & cur_mask) == '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      pc         <= '0;
      last_rdata <= '0;
      aw_addr    <= '0;
      aw_valid   <= 1'b0;
      w_data     <= '0;
      w_valid    <= 1'b0;
      ar_addr    <= '0;
      ar_valid   <= 1'b0;
      cur_op     <= OP_WRITE;
      cur_data   <= '0;
      cur_mask   <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            pc    <= '0;
            done  <= 1'b0;
            error <= 1'b0;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          cur_op   <= f_op;
          cur_data <= f_data;
          cur_mask <= f_mask;
          cnt      <= '0;
          case (f_op)
            OP_WRITE: begin
              aw_addr  <= f_addr;
              w_data   <= f_data;
              aw_valid <= 1'b1;
              w_valid  <= 1'b1;
              state    <= S_WR;
            end
            OP_READ, OP_POLL: begin
              ar_addr  <= f_addr;
              ar_valid <= 1'b1;
              state    <= S_RA;
            end
            OP_END:  state <= S_DONE;
            default: state <= S_DONE;
          endcase
        end
        S_WR: begin
          if (aw_valid && aw_ready) aw_valid <= 1'b0;
          if (w_valid && w_ready) w_valid <= 1'b0;
          if (aw_fin && w_fin) state <= S_WB;
        end
        S_WB: begin
          if (b_valid) state <= (b_resp != 2'b00) ? S_ERR : S_ADV;
        end
        S_RA: begin
          if (ar_ready) begin
            ar_valid <= 1'b0;
            state    <= S_RD;
          end
        end
        S_RD: begin
          if (r_valid) begin
            last_rdata <= r_data;
            if (r_resp != 2'b00) begin
              state <= S_ERR;
            end else if (cur_op == OP_READ || poll_match) begin
              state <= S_ADV;
            end else if (cnt_nxt == POLL_LIMIT) begin
              state <= S_ERR;
            end else begin
              cnt      <= cnt_nxt;
              ar_valid <= 1'b1;
              state    <= S_RA;
            end
          end
        end
        S_ADV: begin
          // The last entry finishes the script rather than wrapping to entry 0.
          if (pc == PC_LAST) begin
            state <= S_DONE;
          end else begin
            pc    <= pc + 1'b1;
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        S_ERR: begin
          busy  <= 1'b0;
          error <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/nasti_lite_stim_seq.md
Name: nasti_lite_stim_seq

Overview:
Programmable stimulus sequencer that masters the narrow NASTI-lite register bus (aw/w/b, ar/r) of peripherals such as osd_dem_uart_nasti.
- It executes a loadable script of WRITE, READ, POLL and END commands.
- POLL repeats a read until masked data matches an expected value, with a timeout.
- The block is the parametrised successor of hard-wired counter/case stimulus. It is used in system testbenches, and is reusable for bring-up of other register-mapped DEMs.

Parameters:
ADDR_WIDTH, 3, bus address width.
DATA_WIDTH, 8, bus data width.
DEPTH, 32, number of script entries (power of two, >=2).
POLL_TIMEOUT, 1024, maximum reads per POLL before error (>=1).
CMD_WIDTH, 2+ADDR_WIDTH+2*DATA_WIDTH, derived script word width. Fields from MSB: op[1:0], addr, data, mask.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
prog_we  in  1  script write strobe
prog_addr  in  $clog2(DEPTH)  script entry index
prog_data  in  CMD_WIDTH  script word
start  in  1  begin execution at entry 0
busy  out  1  script executing
done  out  1  sticky: script ended normally
error  out  1  sticky: bad response or poll timeout
pc  out  $clog2(DEPTH)  current entry index
last_rdata  out  DATA_WIDTH  data of most recent accepted read
aw_addr  out  ADDR_WIDTH  write address
aw_valid  out  1
aw_ready  in  1
w_data  out  DATA_WIDTH
w_valid  out  1
w_ready  in  1
b_resp  in  2
b_valid  in  1
b_ready  out  1  held at 1
ar_addr  out  ADDR_WIDTH
ar_valid  out  1
ar_ready  in  1
r_data  in  DATA_WIDTH
r_resp  in  2
r_valid  in  1
r_ready  out  1  held at 1

Behaviour:
- Opcodes: 0 WRITE, 1 READ, 2 POLL, 3 END.
- Reset:
  - State IDLE.
  - busy, done, error, pc, last_rdata, all valids, addresses and w_data are 0.
  - Script memory is not cleared.
- Script load: prog_we writes the entry only when busy=0; it is ignored while busy.
- States and transitions:
  - IDLE: start=1 -> FETCH. pc=0, done and error cleared, busy=1 from the next cycle.
  - FETCH: latch the entry at pc and the poll counter=0. Then op WRITE->WR, READ/POLL->RA, END->DONE.
  - WR:
    - aw_valid and w_valid rise together one cycle after FETCH.
    - Each channel drops on its own handshake; address and data stay stable while valid.
    - When both channels have completed -> WB.
  - WB: wait for b_valid.
    - b_resp!=0 -> ERR.
    - b_resp=0 -> ADV.
  - RA: ar_valid held until ar_ready -> RD.
  - RD: on r_valid, last_rdata<=r_data.
    - r_resp!=0 -> ERR.
    - READ -> ADV.
    - POLL with (r_data&mask)==(data&mask) -> ADV.
    - POLL without a match: count+1. If count reaches POLL_TIMEOUT -> ERR, else -> RA (re-read, one idle cycle min).
  - ADV:
    - pc=DEPTH-1 -> DONE; pc does not wrap.
    - Otherwise pc+1 -> FETCH.
  - DONE: busy=0, done=1 -> IDLE.
  - ERR: busy=0, error=1, pc frozen at the failing entry -> IDLE.
- start while busy is ignored. start in IDLE clears the previous done/error.
- Responses arriving in states not expecting them are ignored; b_ready and r_ready are constant 1.
- Reset mid-transaction:
  - All valids drop at the reset edge and the state returns to IDLE.
  - Any outstanding response after reset is ignored.
- Minimum costs:
  - WRITE with zero-wait slave: FETCH, WR(1), WB(1 when b in the same cycle), ADV = 4 cycles/command.
  - READ: 4 cycles.

Test Plan:
- Load DLAB sequence (W 3:80, W 0:de, W 0:ad, W 3:00, END) with always-ready slave. Expected: four aw/w handshakes with exact addr/data in order, done=1, error=0, pc=4.
- Slave delays aw_ready 3 cycles but w_ready is immediate. Expected: w_valid drops after 1 cycle, aw_valid holds 3, one b consumed, next command only afterwards.
- POLL addr 5 mask 20 data 20; slave returns 00,00,20. Expected: exactly 3 ar handshakes, last_rdata=20, advance.
- POLL never matching, POLL_TIMEOUT=4. Expected: 4 reads then error=1, busy=0, pc=index of POLL.
- Write with b_resp=2. Expected: error=1, no further aw_valid, prog_we accepted afterwards.
- Assert rst while aw_valid=1. Expected: all valids 0 the next cycle, busy=0. Restart runs from entry 0 with the script intact.
